alu_b_operand_stage: RTL and testbench

- Parametrised, registered successor to the single-cycle ALU-B operand mux, for the pipelined MIPS datapath.
- Selects the ALU B operand from four modes: register, sign-extended immediate, zero-extended immediate, or LUI-shifted immediate.
- In register mode, forwards from the MEM and WB stages.
- Registers the result into an ID/EX-style stage with a valid/ready handshake and a 1-entry skid buffer, so back-pressure never drops or duplicates an operand.

---
 rtl/alu_b_operand_stage_if.sv | 44 ++++
 rtl/alu_b_operand_stage.sv | 134 +++++++++++++
 tb/tb_alu_b_operand_stage.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_b_operand_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_b_operand_stage_if
// Description : Request/response bundle between the ID-side operand request,
//               the forwarding sources and the EX-side ALU B consumer.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_b_operand_stage_if #(
    parameter int WIDTH  = 32,
    parameter int IMM_W  = 16,
    parameter int REG_AW = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        ALUSrc;
    logic [WIDTH-1:0]  read_data2;
    logic [IMM_W-1:0]  imm;
    logic [REG_AW-1:0] rt_addr;
    logic              fwd_mem_en;
    logic [REG_AW-1:0] fwd_mem_addr;
    logic [WIDTH-1:0]  fwd_mem_data;
    logic              fwd_wb_en;
    logic [REG_AW-1:0] fwd_wb_addr;
    logic [WIDTH-1:0]  fwd_wb_data;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  ALU_B;
    logic [1:0]        out_src;

    modport master (
        output in_valid, ALUSrc, read_data2, imm, rt_addr,
               fwd_mem_en, fwd_mem_addr, fwd_mem_data,
               fwd_wb_en, fwd_wb_addr, fwd_wb_data, out_ready,
        input  in_ready, out_valid, ALU_B, out_src
    );

    modport slave (
        input  in_valid, ALUSrc, read_data2, imm, rt_addr,
               fwd_mem_en, fwd_mem_addr, fwd_mem_data,
               fwd_wb_en, fwd_wb_addr, fwd_wb_data, out_ready,
        output in_ready, out_valid, ALU_B, out_src
    );
endinterface
`default_nettype wire

// File: rtl/alu_b_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_b_operand_stage
// Description : Registered ALU B operand select with MEM/WB forwarding and a
//               valid/ready output stage backed by a one-entry skid buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_b_operand_stage #(
    parameter int WIDTH  = 32,
    parameter int IMM_W  = 16,
    parameter int REG_AW = 5
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    alu_b_operand_stage_if.slave  bus
);
    localparam logic [1:0] c_SRC_REG = 2'b00;
    localparam logic [1:0] c_SRC_MEM = 2'b01;
    localparam logic [1:0] c_SRC_WB  = 2'b10;
    localparam logic [1:0] c_SRC_IMM = 2'b11;

    logic [WIDTH-1:0] w_sext;
    logic [WIDTH-1:0] w_zext;
    logic [WIDTH-1:0] w_lui;
    logic [WIDTH-1:0] w_sel_data;
    logic [1:0]       w_sel_src;
    logic             w_mem_hit;
    logic             w_wb_hit;
    logic             w_accept;
    logic             w_consume;
    logic             w_out_load;
    logic             w_skid_valid_nxt;

    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_alu_b;
    logic [1:0]       r_out_src;
    logic             r_skid_valid;
    logic [WIDTH-1:0] r_skid_data;
    logic [1:0]       r_skid_src;

    generate
        if (WIDTH > IMM_W) begin : g_ext
            assign w_sext = {{(WIDTH-IMM_W){bus.imm[IMM_W-1]}}, bus.imm};
            assign w_zext = {{(WIDTH-IMM_W){1'b0}}, bus.imm};
            assign w_lui  = {bus.imm, {(WIDTH-IMM_W){1'b0}}};
        end else begin : g_noext
            assign w_sext = bus.imm;
            assign w_zext = bus.imm;
            assign w_lui  = bus.imm;
        end
    endgenerate

    // Register zero is hard-wired, so a write to it must never be forwarded.
    assign w_mem_hit = bus.fwd_mem_en && (bus.fwd_mem_addr == bus.rt_addr)
                       && (bus.rt_addr != '0);
    assign w_wb_hit  = bus.fwd_wb_en && (bus.fwd_wb_addr == bus.rt_addr)
                       && (bus.rt_addr != '0);

    always_comb begin
        w_sel_data = bus.read_data2;
        w_sel_src  = c_SRC_REG;
        unique case (bus.ALUSrc)
            2'b00: begin
                if (w_mem_hit) begin
                    w_sel_data = bus.fwd_mem_data;
                    w_sel_src  = c_SRC_MEM;
                end else if (w_wb_hit) begin
                    w_sel_data = bus.fwd_wb_data;
                    w_sel_src  = c_SRC_WB;
                end
            end
            2'b01: begin
                w_sel_data = w_sext;
                w_sel_src  = c_SRC_IMM;
            end
            2'b10: begin
                w_sel_data = w_zext;
                w_sel_src  = c_SRC_IMM;
            end
            default: begin
                w_sel_data = w_lui;
                w_sel_src  = c_SRC_IMM;
            end
        endcase
    end

    assign w_accept   = bus.in_valid && r_in_ready;
    assign w_consume  = r_out_valid && bus.out_ready;
    assign w_out_load = !r_out_valid || w_consume;
    // Skid stays occupied only while the output register is stalled.
    assign w_skid_valid_nxt = (r_skid_valid || w_accept) && !w_out_load;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_in_ready   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_alu_b      <= '0;
            r_out_src    <= c_SRC_REG;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_src   <= c_SRC_REG;
        end else begin
            r_in_ready   <= !w_skid_valid_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            if (w_out_load) begin
                if (r_skid_valid) begin
                    r_out_valid <= 1'b1;
                    r_alu_b     <= r_skid_data;
                    r_out_src   <= r_skid_src;
                    if (w_accept) begin
                        r_skid_data <= w_sel_data;
                        r_skid_src  <= w_sel_src;
                    end
                end else if (w_accept) begin
                    r_out_valid <= 1'b1;
                    r_alu_b     <= w_sel_data;
                    r_out_src   <= w_sel_src;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end else if (w_accept) begin
                r_skid_data <= w_sel_data;
                r_skid_src  <= w_sel_src;
            end
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.ALU_B     = r_alu_b;
    assign bus.out_src   = r_out_src;
endmodule
`default_nettype wire

// File: tb/tb_alu_b_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_b_operand_stage
// Description : Directed self-checking bench for alu_b_operand_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_b_operand_stage;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    alu_b_operand_stage_if #(.WIDTH(32), .IMM_W(16), .REG_AW(5)) bif ();

    alu_b_operand_stage #(.WIDTH(32), .IMM_W(16), .REG_AW(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bif.in_valid     = 1'b0;
        bif.ALUSrc       = 2'b00;
        bif.read_data2   = 32'd0;
        bif.imm          = 16'd0;
        bif.rt_addr      = 5'd0;
        bif.fwd_mem_en   = 1'b0;
        bif.fwd_mem_addr = 5'd0;
        bif.fwd_mem_data = 32'd0;
        bif.fwd_wb_en    = 1'b0;
        bif.fwd_wb_addr  = 5'd0;
        bif.fwd_wb_data  = 32'd0;
        bif.out_ready    = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n          = 1'b0;
        bif.in_valid   = 1'b1;
        bif.read_data2 = 32'd5;
        step();
        step();
        n_checks++;
        if (bif.out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_out_valid: got %0b expected 0", bif.out_valid);
        end
        n_checks++;
        if (bif.ALU_B !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_alu_b: got %h expected 00000000", bif.ALU_B);
        end
        n_checks++;
        if (bif.in_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_in_ready: got %0b expected 0", bif.in_ready);
        end
        n_checks++;
        if (bif.out_src !== 2'b00) begin
            n_errors++;
            $display("FAIL reset_out_src: got %b expected 00", bif.out_src);
        end
        rst_n        = 1'b1;
        bif.in_valid = 1'b0;
        step();
        n_checks++;
        if (bif.in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL release_in_ready: got %0b expected 1", bif.in_ready);
        end
    endtask

    task automatic test_modes();
        logic [31:0] exp_data [4];
        logic [1:0]  exp_src  [4];
        exp_data[0] = 32'h0000_0005; exp_src[0] = 2'b00;
        exp_data[1] = 32'hFFFF_800A; exp_src[1] = 2'b11;
        exp_data[2] = 32'h0000_800A; exp_src[2] = 2'b11;
        exp_data[3] = 32'h800A_0000; exp_src[3] = 2'b11;
        idle_inputs();
        for (int m = 0; m < 4; m++) begin
            bif.in_valid   = 1'b1;
            bif.ALUSrc     = m[1:0];
            bif.imm        = 16'h800A;
            bif.read_data2 = 32'd5;
            bif.rt_addr    = 5'd3;
            step();
            bif.in_valid = 1'b0;
            n_checks++;
            if (bif.out_valid !== 1'b1 || bif.ALU_B !== exp_data[m] || bif.out_src !== exp_src[m]) begin
                n_errors++;
                $display("FAIL mode_%0d: got valid=%0b data=%h src=%b expected valid=1 data=%h src=%b",
                         m, bif.out_valid, bif.ALU_B, bif.out_src, exp_data[m], exp_src[m]);
            end
            step();
            n_checks++;
            if (bif.out_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL mode_%0d_drain: out_valid got %0b expected 0", m, bif.out_valid);
            end
        end
    endtask

    task automatic test_forwarding();
        idle_inputs();
        bif.in_valid     = 1'b1;
        bif.rt_addr      = 5'd7;
        bif.read_data2   = 32'd1;
        bif.fwd_mem_en   = 1'b1;
        bif.fwd_mem_addr = 5'd7;
        bif.fwd_mem_data = 32'h22;
        bif.fwd_wb_en    = 1'b1;
        bif.fwd_wb_addr  = 5'd7;
        bif.fwd_wb_data  = 32'h33;
        step();
        n_checks++;
        if (bif.ALU_B !== 32'h22 || bif.out_src !== 2'b01) begin
            n_errors++;
            $display("FAIL fwd_mem_priority: got data=%h src=%b expected data=00000022 src=01",
                     bif.ALU_B, bif.out_src);
        end
        bif.fwd_mem_en = 1'b0;
        step();
        n_checks++;
        if (bif.ALU_B !== 32'h33 || bif.out_src !== 2'b10) begin
            n_errors++;
            $display("FAIL fwd_wb: got data=%h src=%b expected data=00000033 src=10",
                     bif.ALU_B, bif.out_src);
        end
        bif.fwd_mem_en   = 1'b1;
        bif.rt_addr      = 5'd0;
        bif.fwd_mem_addr = 5'd0;
        bif.fwd_wb_addr  = 5'd0;
        step();
        n_checks++;
        if (bif.ALU_B !== 32'h1 || bif.out_src !== 2'b00) begin
            n_errors++;
            $display("FAIL fwd_r0: got data=%h src=%b expected data=00000001 src=00",
                     bif.ALU_B, bif.out_src);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_back_to_back();
        int next_val;
        int idx;
        int budget;
        logic acc;
        idle_inputs();
        bif.in_valid   = 1'b1;
        bif.read_data2 = 32'd1;
        step();
        bif.out_ready  = 1'b0;
        bif.read_data2 = 32'd2;
        step();
        bif.read_data2 = 32'd3;
        n_checks++;
        if (bif.ALU_B !== 32'd1 || bif.out_valid !== 1'b1 || bif.in_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL bp_fill: got data=%h valid=%0b in_ready=%0b expected data=00000001 valid=1 in_ready=0",
                     bif.ALU_B, bif.out_valid, bif.in_ready);
        end
        step();
        step();
        n_checks++;
        if (bif.ALU_B !== 32'd1 || bif.in_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL bp_hold: got data=%h in_ready=%0b expected data=00000001 in_ready=0",
                     bif.ALU_B, bif.in_ready);
        end
        bif.out_ready = 1'b1;
        next_val = 3;
        idx      = 0;
        budget   = 0;
        while (idx < 4 && budget < 20) begin
            acc = bif.in_valid & bif.in_ready;
            if (bif.out_valid === 1'b1) begin
                idx++;
                n_checks++;
                if (bif.ALU_B !== 32'(idx)) begin
                    n_errors++;
                    $display("FAIL bp_order_%0d: got %h expected %h", idx, bif.ALU_B, 32'(idx));
                end
            end
            step();
            budget++;
            if (acc) begin
                next_val++;
                if (next_val > 4) bif.in_valid = 1'b0;
                else bif.read_data2 = 32'(next_val);
            end
        end
        n_checks++;
        if (idx != 4) begin
            n_errors++;
            $display("FAIL bp_timeout: consumed %0d operands expected 4", idx);
        end
        n_checks++;
        if (bif.out_valid !== 1'b0 || bif.in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL bp_empty: got valid=%0b in_ready=%0b expected valid=0 in_ready=1",
                     bif.out_valid, bif.in_ready);
        end
    endtask

    task automatic test_skid_drain();
        idle_inputs();
        bif.in_valid   = 1'b1;
        bif.read_data2 = 32'd10;
        step();
        bif.out_ready  = 1'b0;
        bif.read_data2 = 32'd11;
        step();
        bif.out_ready  = 1'b1;
        bif.read_data2 = 32'd12;
        step();
        n_checks++;
        if (bif.ALU_B !== 32'd11 || bif.out_valid !== 1'b1 || bif.in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL drain_skid: got data=%h valid=%0b in_ready=%0b expected data=0000000b valid=1 in_ready=1",
                     bif.ALU_B, bif.out_valid, bif.in_ready);
        end
        step();
        bif.in_valid = 1'b0;
        n_checks++;
        if (bif.ALU_B !== 32'd12 || bif.out_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL drain_next: got data=%h valid=%0b expected data=0000000c valid=1",
                     bif.ALU_B, bif.out_valid);
        end
        step();
        n_checks++;
        if (bif.out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL drain_empty: out_valid got %0b expected 0", bif.out_valid);
        end
    endtask

    task automatic test_midstream_reset();
        idle_inputs();
        bif.in_valid   = 1'b1;
        bif.read_data2 = 32'd20;
        step();
        bif.out_ready  = 1'b0;
        bif.read_data2 = 32'd21;
        step();
        rst_n = 1'b0;
        step();
        n_checks++;
        if (bif.out_valid !== 1'b0 || bif.in_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL midreset: got valid=%0b in_ready=%0b expected valid=0 in_ready=0",
                     bif.out_valid, bif.in_ready);
        end
        rst_n         = 1'b1;
        bif.in_valid  = 1'b0;
        bif.out_ready = 1'b1;
        step();
        n_checks++;
        if (bif.out_valid !== 1'b0 || bif.in_ready !== 1'b1 || bif.ALU_B !== 32'h0) begin
            n_errors++;
            $display("FAIL midreset_release: got valid=%0b in_ready=%0b data=%h expected valid=0 in_ready=1 data=00000000",
                     bif.out_valid, bif.in_ready, bif.ALU_B);
        end
        bif.in_valid   = 1'b1;
        bif.read_data2 = 32'h55;
        step();
        bif.in_valid = 1'b0;
        n_checks++;
        if (bif.out_valid !== 1'b1 || bif.ALU_B !== 32'h55 || bif.out_src !== 2'b00) begin
            n_errors++;
            $display("FAIL midreset_first: got valid=%0b data=%h src=%b expected valid=1 data=00000055 src=00",
                     bif.out_valid, bif.ALU_B, bif.out_src);
        end
        step();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        idle_inputs();
        test_reset();
        test_modes();
        test_forwarding();
        test_back_to_back();
        test_skid_drain();
        test_midstream_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
